// File: rtl/jericalla_pkg.sv
// Shared definitions for the R-type executor: instruction field positions,
// opcode/funct encodings and the executor FSM state encoding.
package jericalla_pkg;

    // Instruction field positions (MIPS R-type layout)
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned SHAMT_W   = 5;

    // Encodings
    localparam logic [OP_W-1:0]    OP_RTYPE   = 6'h00;
    localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StExec  = 2'd2,
        StWrite = 2'd3
    } state_e;

endpackage

// File: rtl/alu_tipo_r.sv
// Combinational R-type ALU.
// Ports:
//   a_i, b_i   operands (rs, rt values)
//   op_i       opcode field; anything but OP_RTYPE is illegal
//   funct_i    function field selecting the operation
//   result_o   operation result (0 when illegal)
//   legal_o    1 when op/funct name a supported operation
module alu_tipo_r
    import jericalla_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]  a_i,
    input  logic [DATA_W-1:0]  b_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [DATA_W-1:0]  result_o,
    output logic               legal_o
);

    logic slt;
    assign slt = $signed(a_i) < $signed(b_i);

    always_comb begin
        result_o = '0;
        legal_o  = 1'b0;
        if (op_i == OP_RTYPE) begin
            legal_o = 1'b1;
            case (funct_i)
                FUNCT_ADD: result_o = a_i + b_i;
                FUNCT_SUB: result_o = a_i - b_i;
                FUNCT_AND: result_o = a_i & b_i;
                FUNCT_OR:  result_o = a_i | b_i;
                FUNCT_NOR: result_o = ~(a_i | b_i);
                FUNCT_SLT: result_o = {{(DATA_W-1){1'b0}}, slt};
                default:   legal_o  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ejecutor_tipo_r.sv
// Multi-cycle R-type executor. Accepts one instruction per handshake, reads
// rs/rt from the register bank, computes the result and issues a single
// one-cycle write to rd (never to r0, never for an illegal word).
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   INSTR_IN/VALID/READY  instruction handshake (READY high only in idle)
//   RA1_OUT, RA2_OUT      bank read addresses (rs, rt)
//   DR1_IN, DR2_IN        bank read data, combinational from RA1/RA2
//   WA_OUT, DW_OUT, WE_OUT bank write port (WE_OUT level, WRITE state only)
//   DONE, ERR             retire pulse, illegal-instruction pulse
module ejecutor_tipo_r
    import jericalla_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       INSTR_IN,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    output logic [ADDR_W-1:0] RA1_OUT,
    output logic [ADDR_W-1:0] RA2_OUT,
    input  logic [DATA_W-1:0] DR1_IN,
    input  logic [DATA_W-1:0] DR2_IN,
    output logic [ADDR_W-1:0] WA_OUT,
    output logic [DATA_W-1:0] DW_OUT,
    output logic              WE_OUT,
    output logic              DONE,
    output logic              ERR
);

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              legal_q, legal_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_legal;

    // Fields of the latched instruction
    logic [OP_W-1:0]    op_f;
    logic [ADDR_W-1:0]  rs_f, rt_f, rd_f;
    logic [FUNCT_W-1:0] funct_f;
    logic               unused_shamt;

    assign op_f         = instr_q[OP_LSB +: OP_W];
    assign rs_f         = instr_q[RS_LSB +: ADDR_W];
    assign rt_f         = instr_q[RT_LSB +: ADDR_W];
    assign rd_f         = instr_q[RD_LSB +: ADDR_W];
    assign funct_f      = instr_q[FUNCT_LSB +: FUNCT_W];
    assign unused_shamt = ^instr_q[SHAMT_LSB +: SHAMT_W];

    alu_tipo_r #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i      (op1_q),
        .b_i      (op2_q),
        .op_i     (op_f),
        .funct_i  (funct_f),
        .result_o (alu_result),
        .legal_o  (alu_legal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            instr_q  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            legal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            legal_q  <= legal_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        legal_d  = legal_q;
        case (state_q)
            StIdle: begin
                if (INSTR_VALID) begin
                    instr_d = INSTR_IN;
                    state_d = StRead;
                end
            end
            StRead: begin
                op1_d   = DR1_IN;
                op2_d   = DR2_IN;
                state_d = StExec;
            end
            StExec: begin
                result_d = alu_result;
                legal_d  = alu_legal;
                state_d  = StWrite;
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // All outputs decode from registered state only, so WE_OUT cannot glitch.
    always_comb begin
        INSTR_READY = (state_q == StIdle);
        DONE        = (state_q == StWrite);
        ERR         = (state_q == StWrite) && !legal_q;
        WE_OUT      = (state_q == StWrite) && legal_q && (rd_f != '0);
        RA1_OUT     = rs_f;
        RA2_OUT     = rt_f;
        WA_OUT      = rd_f;
        DW_OUT      = result_q;
    end

endmodule

// File: tb/tb_ejecutor_tipo_r.sv
// Directed bench for ejecutor_tipo_r with a behavioural 32x32 register bank.
module tb_ejecutor_tipo_r;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] dr1, dr2, dw;
    logic        we, done, err;

    logic [31:0] bank [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Bank model: combinational read, level write on the rising edge.
    // r0 is deliberately not protected here so a stray r0 write is visible.
    assign dr1 = bank[ra1];
    assign dr2 = bank[ra2];
    always @(posedge clk) if (we) bank[wa] <= dw;

    ejecutor_tipo_r #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .INSTR_IN    (instr_in),
        .INSTR_VALID (instr_valid),
        .INSTR_READY (instr_ready),
        .RA1_OUT     (ra1),
        .RA2_OUT     (ra2),
        .DR1_IN      (dr1),
        .DR2_IN      (dr2),
        .WA_OUT      (wa),
        .DW_OUT      (dw),
        .WE_OUT      (we),
        .DONE        (done),
        .ERR         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ready"}, {31'd0, instr_ready}, 32'd1);
        check({tag, " we"},    {31'd0, we},          32'd0);
        check({tag, " done"},  {31'd0, done},        32'd0);
        check({tag, " err"},   {31'd0, err},         32'd0);
    endtask

    // Issue one instruction and check every cycle of its 4-cycle life.
    task automatic run_instr(input string tag, input logic [31:0] instr,
                             input logic [4:0] rs, input logic [4:0] rt,
                             input logic exp_we, input logic exp_err,
                             input logic [4:0] exp_wa, input logic [31:0] exp_dw);
        @(negedge clk);
        check({tag, " c0 ready"}, {31'd0, instr_ready}, 32'd1);
        instr_in    = instr;
        instr_valid = 1'b1;
        @(negedge clk);                               // cycle 1: READ
        instr_valid = 1'b0;
        check({tag, " c1 ready"}, {31'd0, instr_ready}, 32'd0);
        check({tag, " c1 we"},    {31'd0, we},          32'd0);
        check({tag, " c1 ra1"},   {27'd0, ra1},         {27'd0, rs});
        check({tag, " c1 ra2"},   {27'd0, ra2},         {27'd0, rt});
        @(negedge clk);                               // cycle 2: EXEC
        check({tag, " c2 we"},    {31'd0, we},          32'd0);
        check({tag, " c2 done"},  {31'd0, done},        32'd0);
        @(negedge clk);                               // cycle 3: WRITE
        check({tag, " c3 done"},  {31'd0, done},        32'd1);
        check({tag, " c3 err"},   {31'd0, err},         {31'd0, exp_err});
        check({tag, " c3 we"},    {31'd0, we},          {31'd0, exp_we});
        if (exp_we) begin
            check({tag, " c3 wa"}, {27'd0, wa}, {27'd0, exp_wa});
            check({tag, " c3 dw"}, dw, exp_dw);
        end
        @(negedge clk);                               // cycle 4: IDLE again
        check_idle({tag, " c4"});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'd0;
        rst         = 1'b1;
        instr_in    = 32'd0;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and idle
        check_idle("reset");
        check("reset wa",  {27'd0, wa},  32'd0);
        check("reset dw",  dw,           32'd0);
        check("reset ra1", {27'd0, ra1}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_idle("idle");
        end

        // ADD r3,r1,r2 with r1=5, r2=7
        bank[1] = 32'd5;
        bank[2] = 32'd7;
        run_instr("add", 32'h0022_1820, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 32'd12);
        check("add r3", bank[3], 32'd12);

        // SUB / SLT with a negative operand
        bank[1] = 32'h0000_0003;
        bank[2] = 32'hFFFF_FFFE;
        run_instr("sub", 32'h0022_2022, 5'd1, 5'd2, 1'b1, 1'b0, 5'd4, 32'd5);
        check("sub r4", bank[4], 32'd5);
        run_instr("slt21", 32'h0041_282A, 5'd2, 5'd1, 1'b1, 1'b0, 5'd5, 32'd1);
        check("slt21 r5", bank[5], 32'd1);
        run_instr("slt12", 32'h0022_282A, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 32'd0);
        check("slt12 r5", bank[5], 32'd0);

        // rd=0: retires without error and without writing
        run_instr("rd0", 32'h0022_0020, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 32'd0);
        check("rd0 r0", bank[0], 32'd0);

        // Illegal: non-zero opcode, then unsupported funct (0x21)
        bank[2] = 32'h1111_1111;
        run_instr("badop", 32'h8C22_0000, 5'd1, 5'd2, 1'b0, 1'b1, 5'd0, 32'd0);
        check("badop r0", bank[0], 32'd0);
        bank[3] = 32'hCAFE_0003;
        run_instr("badfn", 32'h0022_1821, 5'd1, 5'd2, 1'b0, 1'b1, 5'd3, 32'd0);
        check("badfn r3", bank[3], 32'hCAFE_0003);

        // Back-to-back: ADD r3,r1,r2 then OR r6,r3,r1 with VALID held
        @(negedge clk);
        bank[1] = 32'd5;
        bank[2] = 32'd7;
        bank[3] = 32'd0;
        bank[6] = 32'd0;
        instr_in    = 32'h0022_1820;
        instr_valid = 1'b1;
        @(negedge clk);                               // cycle 1
        instr_in = 32'h0061_3025;
        check("b2b c1 ready", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);                               // cycle 2
        check("b2b c2 we", {31'd0, we}, 32'd0);
        @(negedge clk);                               // cycle 3
        check("b2b c3 we", {31'd0, we}, 32'd1);
        check("b2b c3 dw", dw, 32'd12);
        @(negedge clk);                               // cycle 4
        check("b2b c4 ready", {31'd0, instr_ready}, 32'd1);
        check("b2b c4 r3", bank[3], 32'd12);
        @(negedge clk);                               // cycle 5: OR in READ
        instr_valid = 1'b0;
        check("b2b c5 ready", {31'd0, instr_ready}, 32'd0);
        check("b2b c5 ra1", {27'd0, ra1}, 32'd3);
        check("b2b c5 ra2", {27'd0, ra2}, 32'd1);
        @(negedge clk);                               // cycle 6
        check("b2b c6 we", {31'd0, we}, 32'd0);
        @(negedge clk);                               // cycle 7: OR WRITE
        check("b2b c7 done", {31'd0, done}, 32'd1);
        check("b2b c7 we", {31'd0, we}, 32'd1);
        check("b2b c7 wa", {27'd0, wa}, 32'd6);
        check("b2b c7 dw", dw, 32'd13);
        @(negedge clk);                               // cycle 8
        check_idle("b2b c8");
        check("b2b r6", bank[6], 32'd13);

        // Two-cycle reset mid-stream clears registered outputs
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst2 a");
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst2 b");
        check("rst2 wa", {27'd0, wa}, 32'd0);
        check("rst2 dw", dw, 32'd0);

        // Reset during EXEC of AND r7,r1,r2 aborts the write
        bank[7] = 32'hDEAD_BEEF;
        @(negedge clk);
        instr_in    = 32'h0022_3824;
        instr_valid = 1'b1;
        @(negedge clk);                               // cycle 1: READ
        instr_valid = 1'b0;
        @(negedge clk);                               // cycle 2: EXEC
        rst = 1'b1;
        check("abort c2 we", {31'd0, we}, 32'd0);
        @(negedge clk);                               // cycle 3 would be WRITE
        rst = 1'b0;
        check_idle("abort c3");
        @(negedge clk);
        check_idle("abort c4");
        @(negedge clk);
        check_idle("abort c5");
        check("abort r7", bank[7], 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
